// File: rtl/instr_queue_if.sv
// Fetch-to-decode handshake bundle for instr_queue.
// master = fetch/decode side driving the queue, slave = the queue itself.
interface instr_queue_if;
   logic [1:0]  in_valid;
   logic [63:0] in_instr;
   logic [31:0] in_pc;
   logic        in_adel;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pcplus4;
   logic        out_in_delay_slot;
   logic        out_is_branch;
   logic        out_adel;

   modport master (
      output in_valid, in_instr, in_pc, in_adel, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_pcplus4,
             out_in_delay_slot, out_is_branch, out_adel
   );

   modport slave (
      input  in_valid, in_instr, in_pc, in_adel, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_pcplus4,
             out_in_delay_slot, out_is_branch, out_adel
   );
endinterface

// File: rtl/instr_queue.sv
// Instruction buffer between fetch and decode: 2-wide push, 1-wide pop, predecode on push.
// Optional macro INSTR_QUEUE_DS_HOLD_EN holds a branch at the head until its delay slot is queued.
module instr_queue #(
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   instr_queue_if.slave q
);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pcplus4;
      logic        ds;
      logic        br;
      logic        adel;
   } entry_t;

   localparam logic [PTR_W:0]   MAX_FILL = (PTR_W+1)'(DEPTH - 2);
   localparam logic [PTR_W:0]   CNT_TWO  = (PTR_W+1)'(2);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             last_br_q, last_br_d;

   entry_t           head_e, e0, e1;
   logic             br0, br1, push0, push1, pop, vld;
   logic [PTR_W:0]   n_push, n_pop;

   function automatic logic is_branch(input logic [5:0] op, input logic [5:0] funct);
      case (op)
         6'b000100, 6'b000101, 6'b000001, 6'b000111,
         6'b000110, 6'b000010, 6'b000011: is_branch = 1'b1;
         6'b000000: is_branch = (funct == 6'b001000) || (funct == 6'b001001);
         default:   is_branch = 1'b0;
      endcase
   endfunction

   always_comb begin
      head_e     = mem_q[head_q];
      q.in_ready = (count_q <= MAX_FILL);

      vld = (count_q != '0);
`ifdef INSTR_QUEUE_DS_HOLD_EN
      // A branch waits for its delay slot; a faulting fetch must still reach decode.
      if (head_e.br && (count_q < CNT_TWO) && !head_e.adel) vld = 1'b0;
`endif
      q.out_valid = vld;

      if (count_q == '0) begin
         q.out_instr         = '0;
         q.out_pc            = '0;
         q.out_pcplus4       = '0;
         q.out_in_delay_slot = 1'b0;
         q.out_is_branch     = 1'b0;
         q.out_adel          = 1'b0;
      end else begin
         q.out_instr         = head_e.instr;
         q.out_pc            = head_e.pc;
         q.out_pcplus4       = head_e.pcplus4;
         q.out_in_delay_slot = head_e.ds;
         q.out_is_branch     = head_e.br;
         q.out_adel          = head_e.adel;
      end

      br0 = is_branch(q.in_instr[31:26], q.in_instr[5:0]);
      br1 = is_branch(q.in_instr[63:58], q.in_instr[37:32]);
      e0  = '{instr: q.in_instr[31:0], pc: q.in_pc, pcplus4: q.in_pc + 32'd4,
              ds: last_br_q, br: br0, adel: q.in_adel};
      e1  = '{instr: q.in_instr[63:32], pc: q.in_pc + 32'd4, pcplus4: q.in_pc + 32'd8,
              ds: br0, br: br1, adel: 1'b0};

      // in_valid=10 is illegal and falls out here as no push
      push0 = q.in_ready && !flush && q.in_valid[0];
      push1 = push0 && q.in_valid[1];
      pop   = vld && q.out_ready && !flush;

      n_push = push1 ? CNT_TWO : (PTR_W+1)'(push0);
      n_pop  = (PTR_W+1)'(pop);

      mem_d = mem_q;
      if (push0) mem_d[tail_q] = e0;
      if (push1) mem_d[tail_q + PTR_ONE] = e1;

      head_d    = head_q + PTR_W'(pop);
      tail_d    = tail_q + PTR_W'(n_push);
      count_d   = count_q + n_push - n_pop;
      last_br_d = push1 ? br1 : (push0 ? br0 : last_br_q);

      if (flush) begin
         head_d    = '0;
         tail_d    = '0;
         count_d   = '0;
         last_br_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         last_br_q <= 1'b0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         last_br_q <= last_br_d;
      end
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus random traffic vs a queue model.
module tb_instr_queue;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset, flush;
   always #5 clk = ~clk;

   instr_queue_if qif ();
   instr_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .flush(flush), .q(qif.slave));

   typedef struct {
      logic [31:0] instr, pc, pcp4;
      logic        ds, br, adel;
   } ent_t;

   ent_t mq[$];
   bit   m_last_br;
   int   errors = 0;
   int   checks = 0;

   function automatic bit m_isbr(input logic [31:0] w);
      logic [5:0] op;
      op = w[31:26];
      if (op inside {6'h04, 6'h05, 6'h01, 6'h07, 6'h06, 6'h02, 6'h03}) return 1'b1;
      if (op == 6'h00 && (w[5:0] == 6'h08 || w[5:0] == 6'h09)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_valid();
      if (mq.size() == 0) return 1'b0;
`ifdef INSTR_QUEUE_DS_HOLD_EN
      if (mq[0].br && mq.size() < 2 && !mq[0].adel) return 1'b0;
`endif
      return 1'b1;
   endfunction

   function automatic bit m_ready();
      return (DEPTH - mq.size()) >= 2;
   endfunction

   // Drives one cycle of stimulus (called with clk low) and advances the model.
   task automatic tick(input logic [1:0] v, input logic [63:0] ins, input logic [31:0] pc,
                       input logic adel, input logic ordy, input logic fl);
      bit rdy, pp;
      ent_t e;
      qif.in_valid  = v;
      qif.in_instr  = ins;
      qif.in_pc     = pc;
      qif.in_adel   = adel;
      qif.out_ready = ordy;
      flush         = fl;
      rdy = m_ready();
      pp  = m_valid() && ordy && !fl;
      @(posedge clk);
      if (fl) begin
         mq.delete();
         m_last_br = 1'b0;
      end else begin
         if (pp) void'(mq.pop_front());
         if (rdy && v[0]) begin
            e = '{instr: ins[31:0], pc: pc, pcp4: pc + 32'd4, ds: m_last_br,
                  br: m_isbr(ins[31:0]), adel: adel};
            mq.push_back(e);
            m_last_br = e.br;
            if (v[1]) begin
               e = '{instr: ins[63:32], pc: pc + 32'd4, pcp4: pc + 32'd8,
                     ds: m_isbr(ins[31:0]), br: m_isbr(ins[63:32]), adel: 1'b0};
               mq.push_back(e);
               m_last_br = e.br;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_pop();
      tick(2'b00, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      flush = 1'b0;
      qif.in_valid = 2'b00; qif.in_instr = '0; qif.in_pc = '0; qif.in_adel = 1'b0;
      qif.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      mq.delete();
      m_last_br = 1'b0;
      checks++; if (qif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", qif.out_valid); end
      checks++; if (qif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", qif.in_ready); end
      checks++;
      if ({qif.out_instr, qif.out_pc, qif.out_pcplus4, qif.out_in_delay_slot, qif.out_is_branch, qif.out_adel} !== '0) begin
         errors++; $display("FAIL reset_data instr=%h pc=%h pc4=%h exp=0", qif.out_instr, qif.out_pc, qif.out_pcplus4);
      end
   endtask

   task automatic test_basic();
      tick(2'b11, {32'h00000000, 32'h24020005}, 32'hBFC00000, 1'b0, 1'b0, 1'b0);
      checks++; if (qif.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", qif.out_valid); end
      checks++;
      if (qif.out_instr !== 32'h24020005 || qif.out_pc !== 32'hBFC00000 || qif.out_pcplus4 !== 32'hBFC00004 || qif.out_in_delay_slot !== 1'b0) begin
         errors++; $display("FAIL basic_e0 instr=%h pc=%h pc4=%h ds=%b exp 24020005/bfc00000/bfc00004/0",
                            qif.out_instr, qif.out_pc, qif.out_pcplus4, qif.out_in_delay_slot);
      end
      idle_pop();
      checks++;
      if (qif.out_instr !== 32'h0 || qif.out_pc !== 32'hBFC00004 || qif.out_pcplus4 !== 32'hBFC00008 || qif.out_in_delay_slot !== 1'b0) begin
         errors++; $display("FAIL basic_e1 instr=%h pc=%h pc4=%h ds=%b exp 00000000/bfc00004/bfc00008/0",
                            qif.out_instr, qif.out_pc, qif.out_pcplus4, qif.out_in_delay_slot);
      end
      idle_pop();
      checks++; if (qif.out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got=%b exp=0", qif.out_valid); end
   endtask

   task automatic test_branch_ds();
      tick(2'b11, {32'h00000000, 32'h10220003}, 32'h00001000, 1'b0, 1'b0, 1'b0);
      checks++;
      if (qif.out_is_branch !== 1'b1 || qif.out_in_delay_slot !== 1'b0) begin
         errors++; $display("FAIL beq_head br=%b ds=%b exp br=1 ds=0", qif.out_is_branch, qif.out_in_delay_slot);
      end
      idle_pop();
      checks++;
      if (qif.out_is_branch !== 1'b0 || qif.out_in_delay_slot !== 1'b1) begin
         errors++; $display("FAIL beq_slot br=%b ds=%b exp br=0 ds=1", qif.out_is_branch, qif.out_in_delay_slot);
      end
      idle_pop();
   endtask

   task automatic test_cross_bundle();
      tick(2'b11, {32'h03E00008, 32'h24020005}, 32'h00002000, 1'b0, 1'b0, 1'b0);
      tick(2'b01, {32'h0, 32'h00000000}, 32'h00002008, 1'b0, 1'b0, 1'b0);
      idle_pop();
      checks++;
      if (qif.out_instr !== 32'h03E00008 || qif.out_is_branch !== 1'b1 || qif.out_in_delay_slot !== 1'b0) begin
         errors++; $display("FAIL jr_head instr=%h br=%b ds=%b exp 03e00008 br=1 ds=0",
                            qif.out_instr, qif.out_is_branch, qif.out_in_delay_slot);
      end
      idle_pop();
      checks++;
      if (qif.out_pc !== 32'h00002008 || qif.out_in_delay_slot !== 1'b1 || qif.out_adel !== 1'b0) begin
         errors++; $display("FAIL cross_ds pc=%h ds=%b adel=%b exp 00002008 ds=1 adel=0",
                            qif.out_pc, qif.out_in_delay_slot, qif.out_adel);
      end
      idle_pop();
   endtask

   task automatic test_fill();
      logic [31:0] pc, exp_pc;
      int pushed, popped, guard;
      pc = 32'h00010000; exp_pc = pc; pushed = 0; popped = 0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (qif.in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got=%b exp=1", i, qif.in_ready); end
         tick(2'b11, {32'h24000000 | (pc + 4), 32'h24000000 | pc}, pc, 1'b0, 1'b0, 1'b0);
         pc += 8; pushed += 2;
      end
      checks++; if (qif.in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got=%b exp=0", qif.in_ready); end
      guard = 0;
      while (guard < 200 && (pushed < 40 || mq.size() != 0)) begin
         bit rdy;
         rdy = m_ready();
         checks++; if (qif.in_ready !== rdy) begin errors++; $display("FAIL stream_ready got=%b exp=%b", qif.in_ready, rdy); end
         if (qif.out_valid === 1'b1) begin
            checks++; if (qif.out_pc !== exp_pc) begin errors++; $display("FAIL stream_order got=%h exp=%h", qif.out_pc, exp_pc); end
            exp_pc += 4; popped++;
         end
         if (pushed < 40) begin
            tick(2'b11, {32'h24000000 | (pc + 4), 32'h24000000 | pc}, pc, 1'b0, 1'b1, 1'b0);
            if (rdy) begin pc += 8; pushed += 2; end
         end else idle_pop();
         guard++;
      end
      checks++; if (popped !== pushed) begin errors++; $display("FAIL stream_count got=%0d exp=%0d", popped, pushed); end
   endtask

   task automatic test_flush();
      tick(2'b11, {32'h0, 32'h24000001}, 32'h3000, 1'b0, 1'b0, 1'b0);
      tick(2'b11, {32'h0, 32'h24000002}, 32'h3008, 1'b0, 1'b0, 1'b0);
      tick(2'b01, {32'h0, 32'h08000010}, 32'h3010, 1'b0, 1'b0, 1'b0);
      checks++; if (mq.size() != 5 || qif.out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre size=%0d valid=%b exp 5/1", mq.size(), qif.out_valid); end
      tick(2'b11, {32'h0, 32'h24000003}, 32'h3014, 1'b0, 1'b1, 1'b1);
      flush = 1'b0;
      checks++;
      if (qif.out_valid !== 1'b0 || qif.in_ready !== 1'b1 || qif.out_instr !== 32'h0) begin
         errors++; $display("FAIL flush_post valid=%b ready=%b instr=%h exp 0/1/0", qif.out_valid, qif.in_ready, qif.out_instr);
      end
      tick(2'b01, {32'h0, 32'h24000004}, 32'h4000, 1'b0, 1'b0, 1'b0);
      checks++;
      if (qif.out_valid !== 1'b1 || qif.out_pc !== 32'h4000 || qif.out_in_delay_slot !== 1'b0) begin
         errors++; $display("FAIL flush_ds valid=%b pc=%h ds=%b exp 1/00004000/0", qif.out_valid, qif.out_pc, qif.out_in_delay_slot);
      end
      idle_pop();
   endtask

   task automatic test_hold();
      tick(2'b01, {32'h0, 32'h08000010}, 32'h5000, 1'b0, 1'b0, 1'b0);
`ifdef INSTR_QUEUE_DS_HOLD_EN
      checks++; if (qif.out_valid !== 1'b0) begin errors++; $display("FAIL hold_j got=%b exp=0", qif.out_valid); end
      tick(2'b01, {32'h0, 32'h00000000}, 32'h5004, 1'b0, 1'b0, 1'b0);
      checks++;
      if (qif.out_valid !== 1'b1 || qif.out_is_branch !== 1'b1) begin
         errors++; $display("FAIL hold_release valid=%b br=%b exp 1/1", qif.out_valid, qif.out_is_branch);
      end
`else
      checks++;
      if (qif.out_valid !== 1'b1 || qif.out_is_branch !== 1'b1) begin
         errors++; $display("FAIL nohold_j valid=%b br=%b exp 1/1", qif.out_valid, qif.out_is_branch);
      end
      tick(2'b01, {32'h0, 32'h00000000}, 32'h5004, 1'b0, 1'b0, 1'b0);
`endif
      idle_pop();
      checks++; if (qif.out_in_delay_slot !== 1'b1) begin errors++; $display("FAIL hold_slot ds=%b exp=1", qif.out_in_delay_slot); end
      idle_pop();
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      logic [5:0]  ops [8];
      ops = '{6'h04, 6'h05, 6'h01, 6'h07, 6'h06, 6'h02, 6'h03, 6'h00};
      w = $urandom;
      case ($urandom_range(0, 3))
         0: w[31:26] = ops[$urandom_range(0, 7)];
         1: begin w[31:26] = 6'h00; w[5:0] = ($urandom_range(0, 1) != 0) ? 6'h08 : 6'h09; end
         default: ;
      endcase
      return w;
   endfunction

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         logic [1:0] v;
         logic [31:0] pc;
         v  = 2'($urandom_range(0, 3));
         pc = {$urandom, 2'b00} ;
         if (i % 97 == 0) pc = 32'hFFFFFFFC;
         tick(v, {rand_word(), rand_word()}, pc, 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
         checks++;
         if (qif.out_valid !== m_valid() || qif.in_ready !== m_ready()) begin
            errors++; $display("FAIL rnd_ctl cyc=%0d valid=%b ready=%b exp %b/%b", i, qif.out_valid, qif.in_ready, m_valid(), m_ready());
         end
         checks++;
         if (mq.size() == 0) begin
            if ({qif.out_instr, qif.out_pc, qif.out_pcplus4, qif.out_in_delay_slot, qif.out_is_branch, qif.out_adel} !== '0) begin
               errors++; $display("FAIL rnd_empty_data cyc=%0d instr=%h pc=%h exp 0", i, qif.out_instr, qif.out_pc);
            end
         end else if (qif.out_instr !== mq[0].instr || qif.out_pc !== mq[0].pc || qif.out_pcplus4 !== mq[0].pcp4 ||
                      qif.out_in_delay_slot !== mq[0].ds || qif.out_is_branch !== mq[0].br || qif.out_adel !== mq[0].adel) begin
            errors++; $display("FAIL rnd_data cyc=%0d got %h/%h/%h/%b%b%b exp %h/%h/%h/%b%b%b", i,
                               qif.out_instr, qif.out_pc, qif.out_pcplus4, qif.out_in_delay_slot, qif.out_is_branch, qif.out_adel,
                               mq[0].instr, mq[0].pc, mq[0].pcp4, mq[0].ds, mq[0].br, mq[0].adel);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_branch_ds();
      test_cross_bundle();
      test_fill();
      test_flush();
      test_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Instruction buffer between fetch and decode.
- Accepts a fetch bundle of up to 2 instruction words per cycle and delivers 1 instruction per cycle to decode.
- Predecodes each word on push to tag branch/jump instructions and to compute each entry's in_delay_slot flag and pcplus4.
- Flushed on redirect (branch mispredict, exception, eret).

Parameters:
DEPTH, 8, number of entries; power of two, at least 4
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
flush  in  1  discard all entries and clear delay-slot tracking
in_valid  in  2  per-slot valid of fetch bundle; bit0 = older word
in_instr  in  64  two 32-bit words; [31:0] = slot0, [63:32] = slot1
in_pc  in  32  PC of slot0; slot1 PC = in_pc+4
in_adel  in  1  fetch address-error flag, applies to slot0 only
in_ready  out  1  queue has at least 2 free entries
out_valid  out  1  head entry presentable to decode
out_ready  in  1  decode accepts head this cycle
out_instr  out  32  head instruction word
out_pc  out  32  head PC
out_pcplus4  out  32  head PC+4
out_in_delay_slot  out  1  head is in a branch/jump delay slot
out_is_branch  out  1  head is branch/jump (predecode)
out_adel  out  1  head carries fetch address error

Behaviour:
- Storage: circular buffer.
  - Registers: head pointer, tail pointer, count (PTR_W+1 bits).
  - Pointers wrap modulo DEPTH.
- Reset (synchronous): head=tail=count=0, last_br=0.
  - Outputs after reset: out_valid=0, in_ready=1; all data outputs 0.
  - Data outputs are forced to 0 whenever count==0.
- Push:
  - Occurs when in_ready && !flush.
  - in_valid=01: push slot0.
  - in_valid=11: push slot0 then slot1.
  - in_valid=00 or 10: no push (10 is illegal and ignored).
- in_ready:
  - Equals (DEPTH - count) >= 2, computed from registered count only.
  - It is not combinationally dependent on out_ready.
- Pop: occurs when out_valid && out_ready && !flush; advances head by 1.
- Simultaneous push and pop in one cycle:
  - count_next = count + pushes - pop.
  - Never overflows, because in_ready reserves 2 slots.
- Flush:
  - Highest priority. Next cycle: head=tail=count=0, last_br=0.
  - Any same-cycle push or pop is dropped.
- Predecode, per word, with op=[31:26] and funct=[5:0]. is_branch=1 iff either:
  - op is one of 000100 (BEQ), 000101 (BNE), 000001 (REGIMM: BGEZ/BLTZ/BGEZAL/BLTZAL), 000111 (BGTZ), 000110 (BLEZ), 000010 (J), 000011 (JAL); or
  - op==000000 and funct is 001000 (JR) or 001001 (JALR).
- Delay-slot tracking:
  - Slot0 in_delay_slot = last_br.
  - Slot1 in_delay_slot = is_branch(slot0).
  - On a push, last_br becomes is_branch of the last word pushed.
  - Tracking crosses bundle boundaries.
  - A branch in a delay slot still sets last_br (architecturally unpredictable, but deterministic here).
- pcplus4 is stored per entry; 32-bit wrap at 0xFFFFFFFC gives 0x00000000.
- adel is stored only with slot0; slot1's stored adel is 0.
- Latency: a word pushed in cycle N is visible at the head in cycle N+1 at the earliest.
- Empty: out_valid=0. Full: in_ready=0 when fewer than 2 slots are free.

Optional Feature:
INSTR_QUEUE_DS_HOLD_EN
- Defined:
  - If the head has is_branch=1 and count<2, out_valid=0.
  - A branch is therefore delivered only when its delay-slot instruction is already queued.
  - An adel head is exempt from the hold.
- Not defined: out_valid = (count!=0).

Test Plan:
- Reset, then push in_valid=11, in_instr={0x00000000, 0x24020005}, in_pc=0xBFC00000 -> next cycles: out_instr=0x24020005, out_pc=0xBFC00000, out_pcplus4=0xBFC00004; then 0x00000000 at 0xBFC00004; out_in_delay_slot=0 for both.
- Push slot0=0x10220003 (BEQ), slot1=0x00000000 -> BEQ entry: out_is_branch=1, out_in_delay_slot=0; second entry: out_in_delay_slot=1.
- Bundle A in_valid=11 ending with 0x03E00008 (JR $ra); bundle B slot0=0x00000000 -> B slot0 entry has out_in_delay_slot=1 (cross-bundle tracking).
- Fill with out_ready=0: in_ready drops after 4 pushes of 2 (DEPTH=8). Then out_ready=1 with in_valid=11 pushing every cycle in_ready permits -> no loss or duplication; entries pop in PC order.
- Flush asserted together with a push and out_ready=1 at count=5 -> next cycle count=0, out_valid=0, in_ready=1. The next pushed word has out_in_delay_slot=0 even if the last word before the flush was a branch.
- With INSTR_QUEUE_DS_HOLD_EN: push only slot0=0x08000010 (J) -> out_valid stays 0. Push its delay slot next cycle -> out_valid=1 the following cycle. Without the macro -> out_valid=1 one cycle after the J push.
